// File: rtl/lstm_step_sched.sv
// Timestep sequencer for one LSTM layer pass: per step, one address-generator run per gate, then one activation run.
// Define LSTM_STEP_SCHED_PERF_EN to add the saturating perf_cycles busy-cycle counter output.
module lstm_step_sched #(
   parameter int NUM_GATES = 4,
   parameter int STEP_BITS = 8,
   parameter int GATE_BITS = 2
) (
   input  logic                 sys_clk,
   input  logic                 reset,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [STEP_BITS-1:0] cmd_steps,
   input  logic                 abort,
   output logic                 ag_start,
   input  logic                 ag_done,
   output logic [GATE_BITS-1:0] gate_sel,
   output logic [STEP_BITS-1:0] step_idx,
   output logic                 act_start,
   input  logic                 act_done,
   output logic                 busy,
   output logic                 done
`ifdef LSTM_STEP_SCHED_PERF_EN
   ,
   output logic [31:0]          perf_cycles
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_AG,
      S_ACT,
      S_WAIT_ACT,
      S_FINISH
   } state_t;

   localparam logic [GATE_BITS-1:0] LAST_GATE = GATE_BITS'(NUM_GATES - 1);
   localparam logic [GATE_BITS-1:0] GATE_ONE  = GATE_BITS'(1);
   localparam logic [STEP_BITS-1:0] STEP_ONE  = STEP_BITS'(1);

   state_t               state_q;
   logic [GATE_BITS-1:0] gate_q;
   logic [STEP_BITS-1:0] step_q;
   logic [STEP_BITS-1:0] steps_q;
   logic [STEP_BITS-1:0] last_step;
   logic                 accept;

   // last_step is only consulted in WAIT_ACT, where steps_q is known to be nonzero
   assign last_step = steps_q - STEP_ONE;
   assign cmd_ready = (state_q == S_IDLE) & ~abort;
   assign accept    = cmd_valid & cmd_ready;

   assign ag_start  = (state_q == S_ISSUE);
   assign act_start = (state_q == S_ACT);
   assign done      = (state_q == S_FINISH);
   assign busy      = (state_q != S_IDLE);
   assign gate_sel  = gate_q;
   assign step_idx  = step_q;

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         gate_q  <= '0;
         step_q  <= '0;
         steps_q <= '0;
      end else if (abort && (state_q != S_IDLE)) begin
         state_q <= S_IDLE;
         gate_q  <= '0;
         step_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  steps_q <= cmd_steps;
                  gate_q  <= '0;
                  step_q  <= '0;
                  state_q <= (cmd_steps == '0) ? S_FINISH : S_ISSUE;
               end
            end
            S_ISSUE: state_q <= S_WAIT_AG;
            S_WAIT_AG: begin
               if (ag_done) begin
                  if (gate_q == LAST_GATE) begin
                     state_q <= S_ACT;
                  end else begin
                     gate_q  <= gate_q + GATE_ONE;
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_ACT: state_q <= S_WAIT_ACT;
            S_WAIT_ACT: begin
               if (act_done) begin
                  if (step_q == last_step) begin
                     state_q <= S_FINISH;
                  end else begin
                     step_q  <= step_q + STEP_ONE;
                     gate_q  <= '0;
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_FINISH: state_q <= S_IDLE;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

`ifdef LSTM_STEP_SCHED_PERF_EN
   logic [31:0] perf_q;

   // Counts every non-IDLE cycle, including the cycle in which an abort is taken
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         perf_q <= '0;
      end else if (state_q == S_IDLE) begin
         if (accept) begin
            perf_q <= '0;
         end
      end else if (perf_q != 32'hFFFF_FFFF) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_lstm_step_sched.sv
// Self-checking bench for lstm_step_sched: randomized handshake delays checked against a cycle-cost model.
// Covers reset, single/multi/zero-step commands, random commands, abort, spurious dones and mid-run reset.
module tb_lstm_step_sched;
   localparam int NG = 4;
   localparam int SB = 8;
   localparam int GB = 2;

   logic          sys_clk   = 1'b0;
   logic          reset     = 1'b1;
   logic          cmd_valid = 1'b0;
   logic [SB-1:0] cmd_steps = '0;
   logic          abort     = 1'b0;
   logic          ag_done   = 1'b0;
   logic          act_done  = 1'b0;
   logic          cmd_ready;
   logic          ag_start;
   logic [GB-1:0] gate_sel;
   logic [SB-1:0] step_idx;
   logic          act_start;
   logic          busy;
   logic          done;
`ifdef LSTM_STEP_SCHED_PERF_EN
   logic [31:0]   perf_cycles;
`endif

   int n_checks = 0;
   int n_pass   = 0;

   int ag_gate_q[$];
   int ag_step_q[$];
   int act_step_q[$];
   int ag_d_q[$];
   int act_d_q[$];
   int obs_done;
   int obs_lat;
   int obs_busy;
   int obs_ready_after;
   logic [31:0] obs_perf;

   lstm_step_sched #(.NUM_GATES(NG), .STEP_BITS(SB), .GATE_BITS(GB)) dut (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_steps (cmd_steps),
      .abort     (abort),
      .ag_start  (ag_start),
      .ag_done   (ag_done),
      .gate_sel  (gate_sel),
      .step_idx  (step_idx),
      .act_start (act_start),
      .act_done  (act_done),
      .busy      (busy),
      .done      (done)
`ifdef LSTM_STEP_SCHED_PERF_EN
      ,
      .perf_cycles (perf_cycles)
`endif
   );

   always #5 sys_clk = ~sys_clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, checks %0d passed of %0d", n_pass, n_checks);
      $fatal(1);
   end

   // Reference cost: every gate is 1 ISSUE cycle plus its wait, every step adds 1 ACT cycle plus its wait,
   // and the FINISH cycle adds one more; an empty command is FINISH alone.
   function automatic int model_latency(input int n);
      int lat;
      if (n == 0) return 1;
      lat = 1;
      foreach (ag_d_q[i]) lat += 1 + ag_d_q[i];
      foreach (act_d_q[i]) lat += 1 + act_d_q[i];
      return lat;
   endfunction

   // Issues one command and plays address generator / activation unit with random reply delays.
   // t counts cycles after the accept edge; observation continues two cycles past done.
   task automatic run_cmd(input int n, input int alo, input int ahi, input int clo, input int chi,
                          input bit spur);
      int t, acnt, ccnt, d;
      ag_gate_q.delete(); ag_step_q.delete(); act_step_q.delete();
      ag_d_q.delete(); act_d_q.delete();
      obs_done = 0; obs_lat = -1; obs_busy = 0; obs_ready_after = -1; obs_perf = '0;
      acnt = 0; ccnt = 0;
      @(negedge sys_clk);
      cmd_steps = SB'(n);
      cmd_valid = 1'b1;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      t = 1;
      while (t <= 2000) begin
         if (busy) obs_busy++;
         if (ag_start) begin
            ag_gate_q.push_back(int'(gate_sel));
            ag_step_q.push_back(int'(step_idx));
         end
         if (act_start) act_step_q.push_back(int'(step_idx));
         if (done) begin
            obs_done++;
            if (obs_lat < 0) obs_lat = t;
         end
         if (obs_lat >= 0 && t == obs_lat + 1) begin
            obs_ready_after = int'(cmd_ready);
`ifdef LSTM_STEP_SCHED_PERF_EN
            obs_perf = perf_cycles;
`endif
         end
         ag_done = 1'b0;
         if (acnt > 0) begin
            acnt--;
            if (acnt == 0) ag_done = 1'b1;
         end
         act_done = 1'b0;
         if (ccnt > 0) begin
            ccnt--;
            if (ccnt == 0) act_done = 1'b1;
         end
         if (ag_start) begin
            d = $urandom_range(ahi, alo);
            ag_d_q.push_back(d);
            acnt = d;
            if (spur) begin
               ag_done  = 1'b1;
               act_done = 1'b1;
            end
         end
         if (act_start) begin
            d = $urandom_range(chi, clo);
            act_d_q.push_back(d);
            ccnt = d;
         end
         if (obs_lat >= 0 && t >= obs_lat + 2) break;
         @(negedge sys_clk);
         t++;
      end
      ag_done  = 1'b0;
      act_done = 1'b0;
   endtask

   task automatic test_reset();
      cmd_valid = 1'b1;
      cmd_steps = SB'($urandom_range(255, 1));
      ag_done   = 1'b1;
      act_done  = 1'b1;
      reset     = 1'b1;
      repeat (3) @(negedge sys_clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (ag_start !== 1'b0) $display("FAIL reset_ag_start: got %b expected 0", ag_start); else n_pass++;
      n_checks++; if (act_start !== 1'b0) $display("FAIL reset_act_start: got %b expected 0", act_start); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
      n_checks++; if (gate_sel !== '0) $display("FAIL reset_gate_sel: got %0d expected 0", gate_sel); else n_pass++;
      n_checks++; if (step_idx !== '0) $display("FAIL reset_step_idx: got %0d expected 0", step_idx); else n_pass++;
      cmd_valid = 1'b0;
      ag_done   = 1'b0;
      act_done  = 1'b0;
      reset     = 1'b0;
      #1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
      $display("test_reset: outputs checked under reset");
   endtask

   task automatic test_single_step();
      run_cmd(1, 1, 1, 1, 1, 1'b0);
      n_checks++; if (obs_lat !== 2 * NG + 3) $display("FAIL single_latency: got %0d expected %0d", obs_lat, 2 * NG + 3); else n_pass++;
      n_checks++; if (ag_gate_q.size() !== NG) $display("FAIL single_ag_count: got %0d expected %0d", ag_gate_q.size(), NG); else n_pass++;
      for (int i = 0; i < ag_gate_q.size(); i++) begin
         n_checks++; if (ag_gate_q[i] !== i) $display("FAIL single_gate_seq[%0d]: got %0d expected %0d", i, ag_gate_q[i], i); else n_pass++;
      end
      n_checks++; if (act_step_q.size() !== 1) $display("FAIL single_act_count: got %0d expected 1", act_step_q.size()); else n_pass++;
      n_checks++; if (obs_done !== 1) $display("FAIL single_done_count: got %0d expected 1", obs_done); else n_pass++;
      n_checks++; if (obs_busy !== 2 * NG + 3) $display("FAIL single_busy_cycles: got %0d expected %0d", obs_busy, 2 * NG + 3); else n_pass++;
`ifdef LSTM_STEP_SCHED_PERF_EN
      n_checks++; if (obs_perf !== 32'(2 * NG + 3)) $display("FAIL single_perf: got %0d expected %0d", obs_perf, 2 * NG + 3); else n_pass++;
`endif
      $display("test_single_step: steps=1 latency=%0d ag=%0d act=%0d", obs_lat, ag_gate_q.size(), act_step_q.size());
   endtask

   task automatic test_multi_step();
      int exp_lat;
      run_cmd(3, 3, 3, 1, 3, 1'b0);
      exp_lat = model_latency(3);
      n_checks++; if (obs_lat !== exp_lat) $display("FAIL multi_latency: got %0d expected %0d", obs_lat, exp_lat); else n_pass++;
      n_checks++; if (ag_gate_q.size() !== 3 * NG) $display("FAIL multi_ag_count: got %0d expected %0d", ag_gate_q.size(), 3 * NG); else n_pass++;
      n_checks++; if (act_step_q.size() !== 3) $display("FAIL multi_act_count: got %0d expected 3", act_step_q.size()); else n_pass++;
      for (int i = 0; i < act_step_q.size(); i++) begin
         n_checks++; if (act_step_q[i] !== i) $display("FAIL multi_act_step[%0d]: got %0d expected %0d", i, act_step_q[i], i); else n_pass++;
      end
      for (int i = 0; i < ag_step_q.size(); i++) begin
         n_checks++;
         if (ag_step_q[i] !== i / NG || ag_gate_q[i] !== i % NG)
            $display("FAIL multi_ag_seq[%0d]: got step %0d gate %0d expected step %0d gate %0d",
                     i, ag_step_q[i], ag_gate_q[i], i / NG, i % NG);
         else n_pass++;
      end
      n_checks++; if (obs_done !== 1) $display("FAIL multi_done_count: got %0d expected 1", obs_done); else n_pass++;
      n_checks++; if (obs_ready_after !== 1) $display("FAIL multi_ready_after_done: got %0d expected 1", obs_ready_after); else n_pass++;
      $display("test_multi_step: steps=3 latency=%0d expected=%0d", obs_lat, exp_lat);
   endtask

   task automatic test_zero_steps();
      run_cmd(0, 1, 1, 1, 1, 1'b0);
      n_checks++; if (obs_lat !== 1) $display("FAIL zero_latency: got %0d expected 1", obs_lat); else n_pass++;
      n_checks++; if (ag_gate_q.size() !== 0) $display("FAIL zero_ag_count: got %0d expected 0", ag_gate_q.size()); else n_pass++;
      n_checks++; if (act_step_q.size() !== 0) $display("FAIL zero_act_count: got %0d expected 0", act_step_q.size()); else n_pass++;
      n_checks++; if (obs_busy !== 1) $display("FAIL zero_busy_cycles: got %0d expected 1", obs_busy); else n_pass++;
      n_checks++; if (obs_done !== 1) $display("FAIL zero_done_count: got %0d expected 1", obs_done); else n_pass++;
      $display("test_zero_steps: latency=%0d busy_cycles=%0d", obs_lat, obs_busy);
   endtask

   task automatic test_random();
      int n, exp_lat;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(5, 1);
         run_cmd(n, 1, 4, 1, 4, 1'b0);
         exp_lat = model_latency(n);
         n_checks++; if (obs_lat !== exp_lat) $display("FAIL rand_latency: iter %0d got %0d expected %0d", it, obs_lat, exp_lat); else n_pass++;
         n_checks++; if (ag_gate_q.size() !== n * NG) $display("FAIL rand_ag_count: iter %0d got %0d expected %0d", it, ag_gate_q.size(), n * NG); else n_pass++;
         n_checks++; if (act_step_q.size() !== n) $display("FAIL rand_act_count: iter %0d got %0d expected %0d", it, act_step_q.size(), n); else n_pass++;
         n_checks++; if (obs_done !== 1) $display("FAIL rand_done_count: iter %0d got %0d expected 1", it, obs_done); else n_pass++;
         for (int i = 0; i < ag_step_q.size(); i++) begin
            n_checks++;
            if (ag_step_q[i] !== i / NG || ag_gate_q[i] !== i % NG)
               $display("FAIL rand_ag_seq: iter %0d idx %0d got step %0d gate %0d expected step %0d gate %0d",
                        it, i, ag_step_q[i], ag_gate_q[i], i / NG, i % NG);
            else n_pass++;
         end
         $display("test_random: iter %0d steps=%0d latency=%0d expected=%0d", it, n, obs_lat, exp_lat);
      end
   endtask

   task automatic test_abort();
      int  t = 0;
      int  nag = 0, nact = 0, ndone = 0;
      bit  hit = 1'b0;
      logic ag_p = 1'b0, act_p = 1'b0;
      @(negedge sys_clk);
      cmd_steps = SB'(4);
      cmd_valid = 1'b1;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      while (!hit && t < 300) begin
         ag_done  = ag_p;
         act_done = act_p;
         ag_p  = ag_start;
         act_p = act_start;
         if (ag_start && gate_sel == 2 && step_idx == 1) hit = 1'b1;
         else begin
            @(negedge sys_clk);
            t++;
         end
      end
      n_checks++; if (hit !== 1'b1) $display("FAIL abort_reach_gate2_step1: got %b expected 1 within budget", hit); else n_pass++;
      @(negedge sys_clk);
      ag_done  = 1'b1;
      act_done = 1'b0;
      abort    = 1'b1;
      @(negedge sys_clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (gate_sel !== '0) $display("FAIL abort_gate_sel: got %0d expected 0", gate_sel); else n_pass++;
      n_checks++; if (step_idx !== '0) $display("FAIL abort_step_idx: got %0d expected 0", step_idx); else n_pass++;
      n_checks++; if (ag_start !== 1'b0) $display("FAIL abort_ag_start: got %b expected 0", ag_start); else n_pass++;
      abort   = 1'b0;
      ag_done = 1'b0;
      #1;
      n_checks++; if (cmd_ready !== 1'b1) $display("FAIL abort_cmd_ready: got %b expected 1", cmd_ready); else n_pass++;
      for (int i = 0; i < 10; i++) begin
         if (ag_start) nag++;
         if (act_start) nact++;
         if (done) ndone++;
         @(negedge sys_clk);
      end
      n_checks++; if (nag !== 0) $display("FAIL abort_quiet_ag: got %0d pulses expected 0", nag); else n_pass++;
      n_checks++; if (nact + ndone !== 0) $display("FAIL abort_quiet_act_done: got %0d pulses expected 0", nact + ndone); else n_pass++;
      $display("test_abort: aborted at gate 2 step 1, ag pulses after=%0d", nag);
   endtask

   task automatic test_spurious();
      int bad = 0;
      int exp_lat;
      for (int i = 0; i < 4; i++) begin
         ag_done  = 1'b1;
         act_done = ($urandom_range(1, 0) == 1);
         @(negedge sys_clk);
         if (busy || ag_start || act_start || done) bad++;
      end
      ag_done  = 1'b0;
      act_done = 1'b0;
      n_checks++; if (bad !== 0) $display("FAIL spur_idle_activity: got %0d active cycles expected 0", bad); else n_pass++;
      run_cmd(1, 2, 4, 1, 3, 1'b1);
      exp_lat = model_latency(1);
      n_checks++; if (ag_gate_q.size() !== NG) $display("FAIL spur_ag_count: got %0d expected %0d", ag_gate_q.size(), NG); else n_pass++;
      n_checks++; if (act_step_q.size() !== 1) $display("FAIL spur_act_count: got %0d expected 1", act_step_q.size()); else n_pass++;
      n_checks++; if (obs_lat !== exp_lat) $display("FAIL spur_latency: got %0d expected %0d", obs_lat, exp_lat); else n_pass++;
      n_checks++; if (obs_done !== 1) $display("FAIL spur_done_count: got %0d expected 1", obs_done); else n_pass++;
      $display("test_spurious: ag=%0d act=%0d latency=%0d", ag_gate_q.size(), act_step_q.size(), obs_lat);
   endtask

   task automatic test_reset_mid();
      int  t = 0;
      bit  hit = 1'b0;
      logic ag_p = 1'b0;
      @(negedge sys_clk);
      cmd_steps = SB'(2);
      cmd_valid = 1'b1;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      while (!hit && t < 200) begin
         ag_done  = ag_p;
         act_done = 1'b0;
         ag_p = ag_start;
         if (act_start) hit = 1'b1;
         else begin
            @(negedge sys_clk);
            t++;
         end
      end
      n_checks++; if (hit !== 1'b1) $display("FAIL rstmid_reach_act: got %b expected 1 within budget", hit); else n_pass++;
      @(negedge sys_clk);
      ag_done  = 1'b0;
      act_done = 1'b1;
      reset    = 1'b1;
      @(negedge sys_clk);
      n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if ({ag_start, act_start, done} !== 3'b000) $display("FAIL rstmid_pulses: got %b expected 000", {ag_start, act_start, done}); else n_pass++;
      n_checks++; if (step_idx !== '0 || gate_sel !== '0) $display("FAIL rstmid_idx: got step %0d gate %0d expected 0 0", step_idx, gate_sel); else n_pass++;
      reset     = 1'b0;
      act_done  = 1'b0;
      cmd_steps = SB'(1);
      cmd_valid = 1'b1;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      n_checks++; if (ag_start !== 1'b1) $display("FAIL rstmid_accept_ag_start: got %b expected 1", ag_start); else n_pass++;
      n_checks++; if (busy !== 1'b1) $display("FAIL rstmid_accept_busy: got %b expected 1", busy); else n_pass++;
      reset = 1'b1;
      @(negedge sys_clk);
      reset = 1'b0;
      $display("test_reset_mid: reset during WAIT_ACT, new command accepted");
   endtask

   initial begin
      test_reset();
      test_single_step();
      test_multi_step();
      test_zero_steps();
      test_random();
      test_abort();
      test_spurious();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/lstm_step_sched.md
Name: lstm_step_sched

Overview:
- Top-level sequencer for one LSTM layer pass on the systolic array.
- For each timestep, issues one start to the temp-buffer address generator per gate (i, f, g, o) and waits for its done.
- After all gates of a step, triggers the activation/elementwise unit.
- Sits between the host command interface and the address generator / activation blocks.

Parameters:
- NUM_GATES, 4, gate phases per timestep (≥2)
- STEP_BITS, 8, width of timestep count/index
- GATE_BITS, 2, width of gate_sel; must satisfy 2**GATE_BITS ≥ NUM_GATES

Ports:
- sys_clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  host command present
- cmd_ready  out  1  scheduler can accept a command
- cmd_steps  in  STEP_BITS  number of timesteps for the command
- abort  in  1  cancel current command
- ag_start  out  1  single-cycle start pulse to address generator
- ag_done  in  1  address generator finished current gate
- gate_sel  out  GATE_BITS  current gate index
- step_idx  out  STEP_BITS  current timestep index
- act_start  out  1  single-cycle start pulse to activation unit
- act_done  in  1  activation unit finished current step
- busy  out  1  high in every state except IDLE
- done  out  1  single-cycle pulse, command complete

Behaviour:
- Reset (sys_clk edge with reset=1): state=IDLE; gate_sel=0, step_idx=0, ag_start=0, act_start=0, done=0, busy=0; internal steps register=0.
- All outputs are registered or decoded from registered state only; no input→output combinational path except cmd_ready = (state==IDLE) & ~abort.
- States: IDLE, ISSUE, WAIT_AG, ACT, WAIT_ACT, FINISH.
- IDLE:
  - On cmd_valid & cmd_ready: latch cmd_steps; clear gate_sel and step_idx.
  - If cmd_steps==0, go to FINISH; else go to ISSUE.
- ISSUE: ag_start=1 for exactly this cycle; go to WAIT_AG.
- WAIT_AG:
  - Hold until ag_done=1.
  - On ag_done: if gate_sel==NUM_GATES-1, go to ACT; else increment gate_sel and go to ISSUE.
- ACT: act_start=1 for exactly this cycle; go to WAIT_ACT.
- WAIT_ACT:
  - Hold until act_done=1.
  - On act_done: if step_idx==steps-1, go to FINISH; else increment step_idx, set gate_sel=0, go to ISSUE.
- FINISH: done=1 for exactly this cycle; go to IDLE. gate_sel and step_idx hold their last values until the next accept.
- Latency:
  - First ag_start occurs 1 cycle after the accept cycle.
  - If ag_done/act_done are high on the first WAIT cycle, each gate costs 2 cycles and each ACT phase costs 2 cycles.
  - Total accept→done = N·(2·NUM_GATES+2)+1 cycles for N≥1; 1 cycle for N=0.
- Spurious inputs:
  - ag_done outside WAIT_AG is ignored.
  - act_done outside WAIT_ACT is ignored.
  - A held-high ag_done counts once per WAIT_AG visit.
- abort:
  - In any non-IDLE state: next state is IDLE, no done pulse, no further start pulses, gate_sel and step_idx cleared.
  - abort takes priority over ag_done, act_done and FINISH.
  - In IDLE: cmd_ready=0 and no command is accepted that cycle.
- reset has priority over abort and all other inputs, in any state.
- Counters: step_idx never exceeds steps-1; no wrap. cmd_steps of 2**STEP_BITS-1 is legal.

Optional Feature:
- Macro: LSTM_STEP_SCHED_PERF_EN.
- Defined:
  - Adds output perf_cycles (out, 32 bits).
  - Cleared to 0 on reset and on each accepted command.
  - Increments by 1 each cycle the state is not IDLE and saturates at 2**32-1.
  - Holds its value in IDLE; abort freezes the current value.
- Not defined: port and counter logic are absent. All other behaviour is identical.

Test Plan:
- cmd_steps=1, ag_done and act_done returned on the first WAIT cycle:
  - 4 ag_start pulses with gate_sel 0,1,2,3, then 1 act_start.
  - done 11 cycles after accept; perf_cycles=11 when LSTM_STEP_SCHED_PERF_EN is defined.
- cmd_steps=3, ag_done returned 3 cycles after each ag_start:
  - 12 ag_start pulses and 3 act_start pulses; step_idx steps 0,1,2.
  - Exactly one done pulse; cmd_ready=1 the cycle after done.
- cmd_steps=0: done exactly 1 cycle after accept; zero ag_start and act_start pulses; busy high for one cycle.
- abort during WAIT_AG of gate 2, step 1 (cmd_steps=4): IDLE next cycle, gate_sel=0, step_idx=0, no done pulse, and no ag_start for 10 subsequent cycles.
- ag_done and act_done pulsed in IDLE and during ISSUE: no state change and no extra start pulses. A following cmd_steps=1 run still produces exactly 4 ag_start pulses.
- reset asserted mid-WAIT_ACT: on the next edge all outputs take their reset values and busy=0. A new command is accepted the cycle after reset deasserts.
